// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks a word-aligned PC through a fixed-latency
// instruction memory and holds one fetched word for decode until it is consumed.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter int          MEM_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_fault,
  output logic [1:0]  dbgState
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, HOLD = 2'd3} fetchState_e;

  localparam logic [31:0] MemWords    = 32'(MEM_WORDS);
  localparam logic [3:0]  LatMinusOne = 4'(MEM_LAT - 1);
  localparam bit          SingleCycle = (MEM_LAT == 1);

  fetchState_e state, nextState;
  logic [31:0] pc;
  logic [3:0]  cnt;
  logic        inRange;
  logic        capture;
  logic        faultCapture;
  logic        advance;
  logic        takeRedirect;
  logic [31:0] redirectAligned;

  assign inRange         = ({2'b00, pc[31:2]} < MemWords);
  assign takeRedirect    = redirect && (state != IDLE);
  assign redirectAligned = redirect_pc & ~32'h3;
  assign dbgState        = state;

  always_comb begin
    nextState    = state;
    mem_rd       = 1'b0;
    capture      = 1'b0;
    faultCapture = 1'b0;
    advance      = 1'b0;
    case (state)
      IDLE: nextState = REQ;
      REQ: begin
        // Out-of-range addresses never touch memory; the fault is reported at once.
        if (!inRange) begin
          faultCapture = 1'b1;
          nextState    = HOLD;
        end else begin
          mem_rd = 1'b1;
          if (SingleCycle) begin
            capture   = 1'b1;
            nextState = HOLD;
          end else begin
            nextState = WAIT;
          end
        end
      end
      WAIT: begin
        mem_rd = 1'b1;
        if (cnt == 4'd1) begin
          capture   = 1'b1;
          nextState = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          advance   = 1'b1;
          nextState = REQ;
        end
      end
      default: nextState = IDLE;
    endcase
    // A redirect discards whatever the current state was about to do.
    if (takeRedirect) begin
      nextState    = REQ;
      capture      = 1'b0;
      faultCapture = 1'b0;
      advance      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      mem_addr <= RESET_PC;
      cnt      <= 4'd0;
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_inst  <= 32'h0;
      if_fault <= 1'b0;
    end else begin
      state <= nextState;
      if (takeRedirect) begin
        pc       <= redirectAligned;
        mem_addr <= redirectAligned;
        cnt      <= 4'd0;
        if_valid <= 1'b0;
        if_fault <= 1'b0;
      end else begin
        if (state == REQ) begin
          cnt <= LatMinusOne;
        end else if (state == WAIT) begin
          cnt <= cnt - 4'd1;
        end
        if (capture) begin
          if_inst  <= mem_data;
          if_pc    <= pc;
          if_fault <= 1'b0;
          if_valid <= 1'b1;
        end
        if (faultCapture) begin
          if_inst  <= 32'h0;
          if_pc    <= pc;
          if_fault <= 1'b1;
          if_valid <= 1'b1;
        end
        if (advance) begin
          pc       <= pc + 32'd4;
          mem_addr <= pc + 32'd4;
          if_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: one instance with single-cycle memory, one with
// three-cycle memory, sharing control inputs; each scenario checks the relevant one.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;

  logic [31:0] aAddr, aData, aPc, aInst;
  logic        aRd, aValid, aFault;
  logic [1:0]  aState;
  logic [31:0] bAddr, bData, bPc, bInst;
  logic        bRd, bValid, bFault;
  logic [1:0]  bState;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_HOLD = 2'd3;

  // Memory contents: word 0 is the reference instruction, others tag their address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h2008_0005;
    return 32'hC0DE_0000 | addr;
  endfunction

  assign aData = memWord(aAddr);
  assign bData = memWord(bAddr);

  fetch_ctrl #(.RESET_PC(32'h0), .MEM_WORDS(1024), .MEM_LAT(1)) uA (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirectPc),
    .mem_addr(aAddr), .mem_rd(aRd), .mem_data(aData), .if_valid(aValid), .if_pc(aPc),
    .if_inst(aInst), .if_fault(aFault), .dbgState(aState)
  );

  fetch_ctrl #(.RESET_PC(32'h0), .MEM_WORDS(1024), .MEM_LAT(3)) uB (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirectPc),
    .mem_addr(bAddr), .mem_rd(bRd), .mem_data(bData), .if_valid(bValid), .if_pc(bPc),
    .if_inst(bInst), .if_fault(bFault), .dbgState(bState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves both instances in IDLE with rst_n released; the next tick enters REQ.
  task automatic doReset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirectPc = 32'h0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b1; redirect = 1'b1; redirectPc = 32'h44;
    tick(); tick();
    checks++; if (aState !== S_IDLE) begin errors++; $display("FAIL reset_stateA got %0d exp %0d", aState, S_IDLE); end
    checks++; if (bState !== S_IDLE) begin errors++; $display("FAIL reset_stateB got %0d exp %0d", bState, S_IDLE); end
    checks++; if (aAddr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", aAddr); end
    checks++; if ({aRd, aValid, aFault} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {aRd, aValid, aFault}); end
    checks++; if ({aPc, aInst} !== 64'h0) begin errors++; $display("FAIL reset_pc_inst got %h exp 0", {aPc, aInst}); end
    checks++; if ({bRd, bValid, bFault} !== 3'b000) begin errors++; $display("FAIL reset_flagsB got %b exp 000", {bRd, bValid, bFault}); end
  endtask

  task automatic test_lat1();
    doReset();
    tick();
    checks++; if ({aState, aAddr, aRd, aValid} !== {S_REQ, 32'h0, 1'b1, 1'b0}) begin errors++; $display("FAIL lat1_req got st=%0d addr=%h rd=%b v=%b exp st=1 addr=0 rd=1 v=0", aState, aAddr, aRd, aValid); end
    tick();
    checks++; if ({aValid, aFault, aRd} !== 3'b100) begin errors++; $display("FAIL lat1_hold_flags got %b exp 100", {aValid, aFault, aRd}); end
    checks++; if (aInst !== 32'h2008_0005) begin errors++; $display("FAIL lat1_inst got %h exp 20080005", aInst); end
    checks++; if (aPc !== 32'h0) begin errors++; $display("FAIL lat1_pc got %h exp 0", aPc); end
    tick();
    checks++; if ({aAddr, aRd, aValid} !== {32'h4, 1'b1, 1'b0}) begin errors++; $display("FAIL lat1_next_req got addr=%h rd=%b v=%b exp addr=4 rd=1 v=0", aAddr, aRd, aValid); end
    tick();
    checks++; if ({aValid, aInst, aPc} !== {1'b1, 32'hC0DE_0004, 32'h4}) begin errors++; $display("FAIL lat1_second got v=%b inst=%h pc=%h exp v=1 inst=c0de0004 pc=4", aValid, aInst, aPc); end
  endtask

  task automatic test_stall();
    doReset();
    tick();
    tick();
    checks++; if (bState !== S_WAIT || bRd !== 1'b1) begin errors++; $display("FAIL lat3_wait got st=%0d rd=%b exp st=2 rd=1", bState, bRd); end
    tick();
    checks++; if (bValid !== 1'b0) begin errors++; $display("FAIL lat3_early_valid got %b exp 0", bValid); end
    tick();
    checks++; if ({bValid, bInst, bPc} !== {1'b1, 32'h2008_0005, 32'h0}) begin errors++; $display("FAIL lat3_capture got v=%b inst=%h pc=%h exp v=1 inst=20080005 pc=0", bValid, bInst, bPc); end
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({bValid, bRd, bInst, bPc, bState} !== {1'b1, 1'b0, 32'h2008_0005, 32'h0, S_HOLD}) begin
        errors++; $display("FAIL stall_hold_%0d got v=%b rd=%b inst=%h pc=%h st=%0d exp v=1 rd=0 inst=20080005 pc=0 st=3", i, bValid, bRd, bInst, bPc, bState);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if ({bAddr, bRd, bValid} !== {32'h4, 1'b1, 1'b0}) begin errors++; $display("FAIL stall_release got addr=%h rd=%b v=%b exp addr=4 rd=1 v=0", bAddr, bRd, bValid); end
  endtask

  task automatic test_redirect_wait();
    doReset();
    tick(); tick(); tick();
    redirect = 1'b1; redirectPc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    checks++; if ({bValid, bState, bAddr, bRd} !== {1'b0, S_REQ, 32'h100, 1'b1}) begin errors++; $display("FAIL redir_wait got v=%b st=%0d addr=%h rd=%b exp v=0 st=1 addr=100 rd=1", bValid, bState, bAddr, bRd); end
    tick(); tick(); tick();
    checks++; if ({bValid, bInst, bPc} !== {1'b1, 32'hC0DE_0100, 32'h100}) begin errors++; $display("FAIL redir_wait_fetch got v=%b inst=%h pc=%h exp v=1 inst=c0de0100 pc=100", bValid, bInst, bPc); end
  endtask

  task automatic test_fault();
    doReset();
    tick();
    redirect = 1'b1; redirectPc = 32'h0000_1000;
    tick();
    redirect = 1'b0;
    checks++; if ({aRd, aValid, aAddr} !== {1'b0, 1'b0, 32'h1000}) begin errors++; $display("FAIL fault_req got rd=%b v=%b addr=%h exp rd=0 v=0 addr=1000", aRd, aValid, aAddr); end
    checks++; if (bRd !== 1'b0) begin errors++; $display("FAIL fault_reqB got rd=%b exp 0", bRd); end
    tick();
    checks++; if ({aValid, aFault, aInst, aPc} !== {1'b1, 1'b1, 32'h0, 32'h1000}) begin errors++; $display("FAIL fault_hold got v=%b f=%b inst=%h pc=%h exp v=1 f=1 inst=0 pc=1000", aValid, aFault, aInst, aPc); end
    checks++; if ({bValid, bFault, bInst, bPc} !== {1'b1, 1'b1, 32'h0, 32'h1000}) begin errors++; $display("FAIL fault_holdB got v=%b f=%b inst=%h pc=%h exp v=1 f=1 inst=0 pc=1000", bValid, bFault, bInst, bPc); end
  endtask

  task automatic test_reset_mid_wait();
    doReset();
    tick();
    redirect = 1'b1; redirectPc = 32'h40;
    tick();
    redirect = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if ({bState, bAddr, bRd, bValid, bFault, bPc, bInst} !== {S_IDLE, 32'h0, 3'b000, 64'h0}) begin
      errors++; $display("FAIL reset_mid_wait got st=%0d addr=%h rd=%b v=%b f=%b pc=%h inst=%h exp all reset", bState, bAddr, bRd, bValid, bFault, bPc, bInst);
    end
    rst_n = 1'b1;
    tick();
    checks++; if ({bAddr, bRd} !== {32'h0, 1'b1}) begin errors++; $display("FAIL reset_restart got addr=%h rd=%b exp addr=0 rd=1", bAddr, bRd); end
    tick(); tick(); tick();
    checks++; if ({bValid, bInst, bPc} !== {1'b1, 32'h2008_0005, 32'h0}) begin errors++; $display("FAIL reset_refetch got v=%b inst=%h pc=%h exp v=1 inst=20080005 pc=0", bValid, bInst, bPc); end
  endtask

  task automatic test_redirect_stall();
    doReset();
    tick(); tick();
    stall = 1'b1; redirect = 1'b1; redirectPc = 32'h20;
    tick();
    redirect = 1'b0; stall = 1'b0;
    checks++; if ({aValid, aState, aAddr} !== {1'b0, S_REQ, 32'h20}) begin errors++; $display("FAIL redir_stall got v=%b st=%0d addr=%h exp v=0 st=1 addr=20", aValid, aState, aAddr); end
    tick();
    checks++; if ({aValid, aInst, aPc} !== {1'b1, 32'hC0DE_0020, 32'h20}) begin errors++; $display("FAIL redir_stall_fetch got v=%b inst=%h pc=%h exp v=1 inst=c0de0020 pc=20", aValid, aInst, aPc); end
  endtask

  task automatic test_redirect_held();
    doReset();
    tick();
    redirect = 1'b1; redirectPc = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({aState, aValid, aAddr} !== {S_REQ, 1'b0, 32'h8}) begin errors++; $display("FAIL redir_held_%0d got st=%0d v=%b addr=%h exp st=1 v=0 addr=8", i, aState, aValid, aAddr); end
    end
    redirect = 1'b0;
    tick();
    checks++; if ({aValid, aInst, aPc} !== {1'b1, 32'hC0DE_0008, 32'h8}) begin errors++; $display("FAIL redir_held_fetch got v=%b inst=%h pc=%h exp v=1 inst=c0de0008 pc=8", aValid, aInst, aPc); end
  endtask

  task automatic test_wrap();
    doReset();
    tick();
    redirect = 1'b1; redirectPc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    tick();
    checks++; if ({aFault, aPc} !== {1'b1, 32'hFFFF_FFFC}) begin errors++; $display("FAIL wrap_fault got f=%b pc=%h exp f=1 pc=fffffffc", aFault, aPc); end
    tick();
    checks++; if ({aAddr, aRd} !== {32'h0, 1'b1}) begin errors++; $display("FAIL wrap_addr got addr=%h rd=%b exp addr=0 rd=1", aAddr, aRd); end
    tick();
    checks++; if ({aValid, aFault, aInst, aPc} !== {1'b1, 1'b0, 32'h2008_0005, 32'h0}) begin errors++; $display("FAIL wrap_fetch got v=%b f=%b inst=%h pc=%h exp v=1 f=0 inst=20080005 pc=0", aValid, aFault, aInst, aPc); end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirectPc = 32'h0;
    test_reset();
    test_lat1();
    test_stall();
    test_redirect_wait();
    test_fault();
    test_reset_mid_wait();
    test_redirect_stall();
    test_redirect_held();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
